prediction_argmax: RTL and testbench

Downstream consumer of the neural network's output layer. It snapshots the ten 16-bit class probabilities when the network signals completion and scans them serially to find the winning digit, the runner-up digit and the winning margin. It holds the result behind a valid/ready handshake for the display/host side, and flags results that were dropped because the previous one had not been consumed.

---
 rtl/prediction_argmax_pkg.sv | 24 ++
 rtl/prediction_argmax_if.sv | 27 ++
 rtl/prediction_argmax_top2.sv | 29 ++
 rtl/prediction_argmax.sv | 120 ++++++++++++
 tb/tb_prediction_argmax.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prediction_argmax_pkg.sv
// Shared sizes, state encoding and candidate record for the argmax scanner.
// Scores are unsigned fixed point with 1.0 = 1 << 11.
package prediction_argmax_pkg;

    localparam int N_CLASSES = 10;
    localparam int PROB_W    = 16;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } argmax_state_t;

    // One ranked candidate; vld distinguishes "no runner-up yet" from a real zero score
    typedef struct packed {
        logic [PROB_W-1:0] val;
        logic [IDX_W-1:0]  idx;
        logic              vld;
    } cand_t;

    typedef logic [N_CLASSES-1:0][PROB_W-1:0] prob_vec_t;

endpackage

// File: rtl/prediction_argmax_if.sv
// Bundle between the network/host side (master) and the argmax scanner (slave).
interface prediction_argmax_if;
    import prediction_argmax_pkg::*;

    logic              R;
    prob_vec_t         Probability;
    logic              Ready;
    logic              ClearOverrun;
    logic              Valid;
    logic              Busy;
    logic [IDX_W-1:0]  Digit;
    logic [PROB_W-1:0] MaxProb;
    logic [IDX_W-1:0]  Second;
    logic [PROB_W-1:0] Margin;
    logic              Overrun;

    modport master (
        output R, Probability, Ready, ClearOverrun,
        input  Valid, Busy, Digit, MaxProb, Second, Margin, Overrun
    );

    modport slave (
        input  R, Probability, Ready, ClearOverrun,
        output Valid, Busy, Digit, MaxProb, Second, Margin, Overrun
    );

endinterface

// File: rtl/prediction_argmax_top2.sv
// Combinational top-two tracker: folds one new score into the current best/second pair.
module top2_update
    import prediction_argmax_pkg::*;
(
    input  cand_t             best_i,
    input  cand_t             second_i,
    input  logic [PROB_W-1:0] val_i,
    input  logic [IDX_W-1:0]  idx_i,
    output cand_t             best_o,
    output cand_t             second_o
);

    cand_t newCand;

    assign newCand = '{val: val_i, idx: idx_i, vld: 1'b1};

    // Strict compares: an equal later score never displaces an earlier index
    always_comb begin
        best_o   = best_i;
        second_o = second_i;
        if (val_i > best_i.val) begin
            second_o = best_i;
            best_o   = newCand;
        end else if (!second_i.vld || (val_i > second_i.val)) begin
            second_o = newCand;
        end
    end

endmodule

// File: rtl/prediction_argmax.sv
// Snapshots the class scores on a rising network-done, scans them one per cycle,
// and holds digit/runner-up/margin behind a valid/ready handshake with overrun flagging.
module prediction_argmax
    import prediction_argmax_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    prediction_argmax_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    argmax_state_t     state_q;
    logic              r_q;
    logic [PROB_W-1:0] snap_q [N_CLASSES];
    cand_t             best_q;
    cand_t             second_q;
    cand_t             best_d;
    cand_t             second_d;
    logic [IDX_W-1:0]  cnt_q;
    logic              valid_q;
    logic [IDX_W-1:0]  digit_q;
    logic [PROB_W-1:0] maxProb_q;
    logic [IDX_W-1:0]  secondIdx_q;
    logic [PROB_W-1:0] margin_q;
    logic              overrun_q;

    logic rEdge;
    logic startScan;
    logic overrunSet;

    // A handshake completing in HOLD frees the scanner in the same cycle as a new edge
    assign rEdge      = bus.R & ~r_q;
    assign startScan  = rEdge & ((state_q == IDLE) | ((state_q == HOLD) & bus.Ready));
    assign overrunSet = rEdge & ((state_q == SCAN) | ((state_q == HOLD) & ~bus.Ready));

    top2_update u_top2 (
        .best_i   (best_q),
        .second_i (second_q),
        .val_i    (snap_q[cnt_q]),
        .idx_i    (cnt_q),
        .best_o   (best_d),
        .second_o (second_d)
    );

    // r_q resets high so a level already asserted at reset release is not taken as an edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            r_q         <= 1'b1;
            for (int k = 0; k < N_CLASSES; k++) begin
                snap_q[k] <= '0;
            end
            best_q      <= '0;
            second_q    <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            digit_q     <= '0;
            maxProb_q   <= '0;
            secondIdx_q <= '0;
            margin_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            r_q <= bus.R;

            if (overrunSet) begin
                overrun_q <= 1'b1;
            end else if (bus.ClearOverrun) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                end
                SCAN: begin
                    best_q   <= best_d;
                    second_q <= second_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        digit_q     <= best_d.idx;
                        maxProb_q   <= best_d.val;
                        secondIdx_q <= second_d.idx;
                        margin_q    <= best_d.val - second_d.val;
                        valid_q     <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.Ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Element 0 preloads the leader, so the scan proper starts at index 1
            if (startScan) begin
                for (int k = 0; k < N_CLASSES; k++) begin
                    snap_q[k] <= bus.Probability[k];
                end
                best_q   <= '{val: bus.Probability[0], idx: '0, vld: 1'b1};
                second_q <= '0;
                cnt_q    <= IDX_W'(1);
                state_q  <= SCAN;
            end
        end
    end

    assign bus.Valid   = valid_q;
    assign bus.Busy    = (state_q == SCAN);
    assign bus.Digit   = digit_q;
    assign bus.MaxProb = maxProb_q;
    assign bus.Second  = secondIdx_q;
    assign bus.Margin  = margin_q;
    assign bus.Overrun = overrun_q;

endmodule

// File: tb/tb_prediction_argmax.sv
// Directed bench for prediction_argmax: a table of score vectors with hand-computed
// winners, followed by handshake, overrun and reset corner sequences.
module tb_prediction_argmax;
    import prediction_argmax_pkg::*;

    typedef struct {
        prob_vec_t probs;
        int        expDigit;
        int        expSecond;
        int        expMax;
        int        expMargin;
    } vector_t;

    localparam int NUM_VEC = 7;
    localparam int SCAN_LAT = N_CLASSES - 1;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   lat;
    logic sawBusy;

    vector_t   vectors [NUM_VEC];
    prob_vec_t ascVec;
    prob_vec_t descVec;

    prediction_argmax_if bus ();

    prediction_argmax dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int d, input int s, input int m, input int mg);
        check({tag, ".Digit"},   int'(bus.Digit),   d);
        check({tag, ".Second"},  int'(bus.Second),  s);
        check({tag, ".MaxProb"}, int'(bus.MaxProb), m);
        check({tag, ".Margin"},  int'(bus.Margin),  mg);
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.Valid && cycles < 30);
    endtask

    // Raises R with the given scores, scrambles the bus after the edge, waits for Valid
    task automatic applyStimulus(input string tag, input prob_vec_t p);
        int cyc;
        @(negedge clk);
        bus.Probability = p;
        bus.R = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".busy_after_edge"}, int'(bus.Busy), 1);
        check({tag, ".valid_after_edge"}, int'(bus.Valid), 0);
        @(negedge clk);
        bus.Probability = '1;
        waitValid(cyc);
        check({tag, ".latency"}, cyc, SCAN_LAT);
        check({tag, ".busy_at_valid"}, int'(bus.Busy), 0);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus.Ready = 1'b1;
        bus.R = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".valid_after_ready"}, int'(bus.Valid), 0);
        @(negedge clk);
        bus.Ready = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.R = 1'b0;
        bus.Probability = '0;
        bus.Ready = 1'b0;
        bus.ClearOverrun = 1'b0;

        for (int i = 0; i < N_CLASSES; i++) begin
            ascVec[i]  = PROB_W'(100 * (i + 1));
            descVec[i] = PROB_W'(1000 - 100 * i);
        end

        vectors[0] = '{ascVec, 9, 8, 1000, 100};
        vectors[1].probs = '0;
        for (int i = 0; i < N_CLASSES; i++) vectors[1].probs[i] = 16'd2048;
        vectors[1].expDigit = 0; vectors[1].expSecond = 1;
        vectors[1].expMax = 2048; vectors[1].expMargin = 0;
        vectors[2].probs = '0;
        for (int i = 0; i < N_CLASSES; i++) vectors[2].probs[i] = 16'd10;
        vectors[2].probs[3] = 16'd1500;
        vectors[2].probs[7] = 16'd1500;
        vectors[2].expDigit = 3; vectors[2].expSecond = 7;
        vectors[2].expMax = 1500; vectors[2].expMargin = 0;
        vectors[3] = '{descVec, 0, 1, 1000, 100};
        vectors[4].probs = '0;
        for (int i = 0; i < N_CLASSES; i++) vectors[4].probs[i] = 16'd1;
        vectors[4].probs[0] = 16'd500;
        vectors[4].probs[9] = 16'd600;
        vectors[4].expDigit = 9; vectors[4].expSecond = 0;
        vectors[4].expMax = 600; vectors[4].expMargin = 100;
        vectors[5].probs = '0;
        vectors[5].probs[5] = 16'd7;
        vectors[5].expDigit = 5; vectors[5].expSecond = 0;
        vectors[5].expMax = 7; vectors[5].expMargin = 7;
        vectors[6].probs = '0;
        vectors[6].probs[2] = 16'hFFFE;
        vectors[6].probs[4] = 16'hFFFF;
        vectors[6].expDigit = 4; vectors[6].expSecond = 2;
        vectors[6].expMax = 65535; vectors[6].expMargin = 1;

        #12;
        check("reset.Valid",   int'(bus.Valid),   0);
        check("reset.Busy",    int'(bus.Busy),    0);
        check("reset.Overrun", int'(bus.Overrun), 0);
        checkOutput("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NUM_VEC; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            applyStimulus(tag, vectors[v].probs);
            checkOutput(tag, vectors[v].expDigit, vectors[v].expSecond,
                        vectors[v].expMax, vectors[v].expMargin);
            consume(tag);
            check({tag, ".no_overrun"}, int'(bus.Overrun), 0);
        end

        // Second edge while a result is pending and Ready is low
        applyStimulus("hold", ascVec);
        @(negedge clk);
        bus.R = 1'b0;
        @(negedge clk);
        bus.R = 1'b1;
        bus.Probability = descVec;
        @(posedge clk);
        #1;
        check("hold.overrun_set", int'(bus.Overrun), 1);
        check("hold.valid_kept",  int'(bus.Valid),   1);
        check("hold.busy_low",    int'(bus.Busy),    0);
        @(negedge clk);
        bus.R = 1'b0;
        @(negedge clk);
        bus.R = 1'b1;
        bus.ClearOverrun = 1'b1;
        @(posedge clk);
        #1;
        check("hold.set_wins", int'(bus.Overrun), 1);
        @(posedge clk);
        #1;
        check("hold.cleared", int'(bus.Overrun), 0);
        @(negedge clk);
        bus.ClearOverrun = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold.stable", 9, 8, 1000, 100);
        consume("hold");

        // Edge during SCAN is dropped and flagged; the running scan is unaffected
        @(negedge clk);
        bus.Probability = ascVec;
        bus.R = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.R = 1'b0;
        bus.Probability = descVec;
        @(negedge clk);
        bus.R = 1'b1;
        @(posedge clk);
        #1;
        check("scan.overrun_set", int'(bus.Overrun), 1);
        check("scan.busy_kept",   int'(bus.Busy),    1);
        waitValid(lat);
        check("scan.latency_rest", lat, SCAN_LAT - 2);
        checkOutput("scan", 9, 8, 1000, 100);
        consume("scan");
        @(negedge clk);
        bus.ClearOverrun = 1'b1;
        @(negedge clk);
        bus.ClearOverrun = 1'b0;
        check("scan.cleared", int'(bus.Overrun), 0);

        // Ready and a fresh edge in the same cycle restart directly, no overrun
        applyStimulus("b2b", ascVec);
        @(negedge clk);
        bus.R = 1'b0;
        @(negedge clk);
        bus.Ready = 1'b1;
        bus.R = 1'b1;
        bus.Probability = descVec;
        @(posedge clk);
        #1;
        check("b2b.no_overrun", int'(bus.Overrun), 0);
        check("b2b.busy",       int'(bus.Busy),    1);
        check("b2b.valid_low",  int'(bus.Valid),   0);
        @(negedge clk);
        bus.Ready = 1'b0;
        bus.Probability = '1;
        waitValid(lat);
        check("b2b.latency", lat, SCAN_LAT);
        checkOutput("b2b", 0, 1, 1000, 100);
        consume("b2b");

        // Asynchronous reset mid-scan with R left high
        applyStimulus("pre_rst", vectors[4].probs);
        consume("pre_rst");
        @(negedge clk);
        bus.Probability = ascVec;
        bus.R = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.Busy",    int'(bus.Busy),    0);
        check("midrst.Valid",   int'(bus.Valid),   0);
        check("midrst.Overrun", int'(bus.Overrun), 0);
        checkOutput("midrst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sawBusy = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.Busy || bus.Valid) sawBusy = 1'b1;
        end
        check("midrst.no_restart", int'(sawBusy), 0);
        @(negedge clk);
        bus.R = 1'b0;
        applyStimulus("post_rst", ascVec);
        checkOutput("post_rst", 9, 8, 1000, 100);
        consume("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
